// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
// Iterative signed multiply / divide for the execute stage.
//   op = 0 : 16x16 signed multiply, 32-bit product on {result_hi, result_lo}
//   op = 1 : 16/16 signed divide, quotient on result_lo, remainder on result_hi
// The operation runs on magnitudes for WIDTH iterations, then a single fix-up
// cycle applies the signs and registers the results.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset, aborts any operation
//   start        operation request, only looked at while idle
//   op           0 = multiply, 1 = divide
//   a, b         two's complement operands (multiplicand/dividend, multiplier/divisor)
//   busy         high while an operation occupies the unit
//   done         one-cycle pulse when results are valid
//   result_lo    product low half or quotient
//   result_hi    product high half or remainder
//   div_by_zero  set alongside done when a divide had a zero divisor
// -----------------------------------------------------------------------------
module mul_div_unit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic                 op_q, op_d;
    logic                 sign_q, sign_d;       // sign(a) XOR sign(b)
    logic                 sign_a_q, sign_a_d;   // sign of the dividend / multiplicand
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;         // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]     opb_q, opb_d;         // mul: |multiplicand|; div: |divisor|
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     res_lo_q, res_lo_d;
    logic [WIDTH-1:0]     res_hi_q, res_hi_d;
    logic                 dbz_q, dbz_d;

    logic [WIDTH-1:0]     a_mag_s;
    logic [WIDTH-1:0]     b_mag_s;
    logic [WIDTH:0]       mul_sum_s;
    logic [2*WIDTH-1:0]   mul_next_s;
    logic [WIDTH:0]       div_shift_s;
    logic [WIDTH:0]       div_diff_s;
    logic [2*WIDTH-1:0]   div_next_s;
    logic [2*WIDTH-1:0]   prod_fix_s;
    logic [WIDTH-1:0]     quo_fix_s;
    logic [WIDTH-1:0]     rem_fix_s;

    // Operand magnitudes, one iteration of each algorithm, and the sign fix-up.
    always_comb begin
        // 8000 maps onto itself, which is the correct unsigned magnitude.
        a_mag_s     = a[WIDTH-1] ? ({WIDTH{1'b0}} - a) : a;
        b_mag_s     = b[WIDTH-1] ? ({WIDTH{1'b0}} - b) : b;

        // Shift-add: add the multiplicand into the upper half when the current
        // multiplier LSB is set, then shift the whole accumulator right, carry included.
        mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
        if (acc_q[0]) begin
            mul_next_s = {mul_sum_s, acc_q[WIDTH-1:1]};
        end else begin
            mul_next_s = {1'b0, acc_q[2*WIDTH-1:1]};
        end

        // Restoring division: shift the next dividend bit into the remainder,
        // keep the difference only when it did not go negative.
        div_shift_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, opb_q};
        if (!div_diff_s[WIDTH]) begin
            div_next_s = {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_next_s = {div_shift_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end

        prod_fix_s  = sign_q   ? ({(2*WIDTH){1'b0}} - acc_q) : acc_q;
        quo_fix_s   = sign_q   ? ({WIDTH{1'b0}} - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
        rem_fix_s   = sign_a_q ? ({WIDTH{1'b0}} - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sign_d   = sign_q;
        sign_a_d = sign_a_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        dbz_d    = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op && (b == {WIDTH{1'b0}})) begin
                        state_d  = S_DONE;
                        res_lo_d = {WIDTH{1'b1}};
                        res_hi_d = a;
                        dbz_d    = 1'b1;
                    end else begin
                        state_d  = S_RUN;
                        op_d     = op;
                        sign_d   = a[WIDTH-1] ^ b[WIDTH-1];
                        sign_a_d = a[WIDTH-1];
                        cnt_d    = {CNT_W{1'b0}};
                        if (op) begin
                            acc_d = {{WIDTH{1'b0}}, a_mag_s};
                            opb_d = b_mag_s;
                        end else begin
                            acc_d = {{WIDTH{1'b0}}, b_mag_s};
                            opb_d = a_mag_s;
                        end
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d = op_q ? div_next_s : mul_next_s;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_FIX: begin
                if (op_q) begin
                    res_lo_d = quo_fix_s;
                    res_hi_d = rem_fix_s;
                end else begin
                    res_lo_d = prod_fix_s[WIDTH-1:0];
                    res_hi_d = prod_fix_s[2*WIDTH-1:WIDTH];
                end
                dbz_d   = 1'b0;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status flags are registered from the next state so they line up with it.
        busy_d = (state_d == S_RUN) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= 1'b0;
            sign_q   <= 1'b0;
            sign_a_q <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
            acc_q    <= {(2*WIDTH){1'b0}};
            opb_q    <= {WIDTH{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            res_lo_q <= {WIDTH{1'b0}};
            res_hi_q <= {WIDTH{1'b0}};
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sign_q   <= sign_d;
            sign_a_q <= sign_a_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result_lo   = res_lo_q;
    assign result_hi   = res_hi_q;
    assign div_by_zero = dbz_q;

endmodule
